// File: rtl/grayscale_stream.sv
// Pixel conversion stage: pulls RGB words from a FWFT FIFO, converts them per
// pixel mode through a 2-stage stallable pipeline and counts pixels per frame.
module grayscale_stream #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int FRAME_PIXELS  = 388800,
  localparam int W  = CHANNEL_WIDTH,
  localparam int CW = $clog2(FRAME_PIXELS + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      mode,
  input  logic [3*W-1:0]  in_dout,
  input  logic            in_empty,
  output logic            in_rd_en,
  output logic [3*W-1:0]  out_din,
  input  logic            out_full,
  output logic            out_wr_en,
  output logic            frame_done,
  output logic [CW-1:0]   pixel_count,
  output logic            busy
);

  localparam int SW = W + 2;
  localparam int LW = W + 9;
  localparam logic [SW-1:0] THREE = SW'(3);
  localparam logic [CW-1:0] LAST  = CW'(FRAME_PIXELS - 1);

  logic [W-1:0]    r_in, g_in, b_in, max_rg, max_in;
  logic [SW-1:0]   sum_in;
  logic [LW-1:0]   luma_in;

  logic            v1_q, v1_d, v2_q, v2_d;
  logic [1:0]      mode1_q, mode1_d;
  logic [3*W-1:0]  pix1_q, pix1_d;
  logic [SW-1:0]   sum1_q, sum1_d;
  logic [LW-1:0]   luma1_q, luma1_d;
  logic [W-1:0]    max1_q, max1_d;
  logic [3*W-1:0]  out_q, out_d, res;
  logic [W-1:0]    y;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            s1_ready, s2_ready;

  // Handshake: a stage accepts when it is empty or its contents move on this
  // edge; S2 moves only when the output FIFO is not full. A word transfers on
  // any edge where both sides' enable (in_rd_en / out_wr_en) is high.
  assign s2_ready   = !v2_q || !out_full;
  assign s1_ready   = !v1_q || s2_ready;
  assign in_rd_en   = reset && !in_empty && s1_ready;
  assign out_wr_en  = v2_q && !out_full;
  assign frame_done = out_wr_en && (cnt_q == LAST);
  assign out_din    = out_q;
  assign pixel_count = cnt_q;
  assign busy       = v1_q || v2_q;

  assign b_in = in_dout[W-1:0];
  assign g_in = in_dout[2*W-1:W];
  assign r_in = in_dout[3*W-1:2*W];

  always_comb begin
    sum_in  = SW'(r_in) + SW'(g_in) + SW'(b_in);
    luma_in = LW'(r_in) * LW'(77) + LW'(g_in) * LW'(150) + LW'(b_in) * LW'(29) + LW'(128);
    max_rg  = (r_in > g_in) ? r_in : g_in;
    max_in  = (max_rg > b_in) ? max_rg : b_in;
  end

  // Stage 1 captures the raw pixel, its mode and the full-width intermediates.
  always_comb begin
    v1_d    = v1_q;
    mode1_d = mode1_q;
    pix1_d  = pix1_q;
    sum1_d  = sum1_q;
    luma1_d = luma1_q;
    max1_d  = max1_q;
    if (s1_ready) begin
      v1_d = in_rd_en;
      if (in_rd_en) begin
        mode1_d = mode;
        pix1_d  = in_dout;
        sum1_d  = sum_in;
        luma1_d = luma_in;
        max1_d  = max_in;
      end
    end
  end

  always_comb begin
    y = '0;
    case (mode1_q)
      2'd1:    y = W'(sum1_q / THREE);
      2'd2:    y = W'(luma1_q >> 8);
      2'd3:    y = max1_q;
      default: y = '0;
    endcase
    res = (mode1_q == 2'd0) ? pix1_q : {y, y, y};
  end

  always_comb begin
    v2_d  = v2_q;
    out_d = out_q;
    if (s2_ready) begin
      v2_d = v1_q;
      if (v1_q) out_d = res;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (frame_done)     cnt_d = '0;
    else if (out_wr_en) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      mode1_q <= '0;
      pix1_q  <= '0;
      sum1_q  <= '0;
      luma1_q <= '0;
      max1_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      mode1_q <= mode1_d;
      pix1_q  <= pix1_d;
      sum1_q  <= sum1_d;
      luma1_q <= luma1_d;
      max1_q  <= max1_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_grayscale_stream.sv
// Randomised scoreboard bench for grayscale_stream with a small frame size.
module tb_grayscale_stream;
  localparam int W  = 8;
  localparam int F  = 4;
  localparam int CW = $clog2(F + 1);

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      mode = '0;
  logic [3*W-1:0]  in_dout = '0;
  logic            in_empty = 1'b0;
  logic            in_rd_en;
  logic [3*W-1:0]  out_din;
  logic            out_full = 1'b0;
  logic            out_wr_en;
  logic            frame_done;
  logic [CW-1:0]   pixel_count;
  logic            busy;

  grayscale_stream #(.CHANNEL_WIDTH(W), .FRAME_PIXELS(F)) dut (
    .clock(clock), .reset(reset), .mode(mode), .in_dout(in_dout),
    .in_empty(in_empty), .in_rd_en(in_rd_en), .out_din(out_din),
    .out_full(out_full), .out_wr_en(out_wr_en), .frame_done(frame_done),
    .pixel_count(pixel_count), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3*W-1:0] exp_q[$];
  int             exp_cyc_q[$];
  int  cyc = 0;
  int  wr_total = 0;
  int  fd_cnt = 0;
  bit  chk_lat = 1'b1;
  bit  bp_en = 1'b0;
  bit  held_v = 1'b0;
  logic [3*W-1:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3*W-1:0] ref_model(input logic [3*W-1:0] px, input logic [1:0] m);
    int r, g, b, yi;
    logic [W-1:0] yb;
    r = int'(px[23:16]);
    g = int'(px[15:8]);
    b = int'(px[7:0]);
    case (m)
      2'd1:    yi = (r + g + b) / 3;
      2'd2:    yi = (77 * r + 150 * g + 29 * b + 128) / 256;
      2'd3:    yi = (r > g) ? ((r > b) ? r : b) : ((g > b) ? g : b);
      default: yi = 0;
    endcase
    yb = yi[W-1:0];
    return (m == 2'd0) ? px : {yb, yb, yb};
  endfunction

  // Monitor: samples on the falling edge, i.e. what the next rising edge commits.
  initial begin : monitor
    int lat;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        exp_q.delete();
        exp_cyc_q.delete();
        wr_total = 0;
        fd_cnt = 0;
        held_v = 1'b0;
      end else begin
        if (out_wr_en) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(out_din), 32'hFFFF_FFFF);
          end else begin
            check("out_din", 32'(out_din), 32'(exp_q.pop_front()));
            lat = cyc - exp_cyc_q.pop_front();
            if (chk_lat) check("latency", 32'(lat), 32'd2);
            check("pixel_count_at_write", 32'(pixel_count), 32'(wr_total % F));
            check("frame_done", 32'(frame_done), 32'((wr_total % F) == F - 1));
            if (frame_done) fd_cnt++;
            wr_total++;
          end
        end else begin
          check("frame_done_idle", 32'(frame_done), 32'd0);
        end
        if (out_full) check("write_while_full", 32'(out_wr_en), 32'd0);
        if (held_v) check("out_din_stable", 32'(out_din), 32'(held));
        held_v = out_full && busy && exp_q.size() > 0 && out_din == exp_q[0];
        held = out_din;
        if (in_rd_en) begin
          exp_q.push_back(ref_model(in_dout, mode));
          exp_cyc_q.push_back(cyc);
        end
      end
    end
  end

  initial begin : backpressure
    forever begin
      @(posedge clock);
      #1;
      if (bp_en) out_full = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [3*W-1:0] px, input logic [1:0] m);
    bit acc;
    acc = 1'b0;
    in_dout = px;
    mode = m;
    in_empty = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clock);
      acc = in_rd_en;
      @(posedge clock);
      #1;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    in_empty = 1'b1;
    in_dout = 24'($urandom);
    mode = 2'($urandom_range(0, 3));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge clock);
      #1;
      done = (exp_q.size() == 0) && !busy;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #3 reset = 1'b0;
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_wr_en"}, 32'(out_wr_en), 32'd0);
    check({tag, "_in_rd_en"}, 32'(in_rd_en), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pixel_count"}, 32'(pixel_count), 32'd0);
    check({tag, "_out_din"}, 32'(out_din), 32'd0);
  endtask

  initial begin : stimulus
    logic [3*W-1:0] px;
    // Reset state, with input available so in_rd_en must be held low by reset.
    in_empty = 1'b0;
    in_dout = 24'hABCDEF;
    #2 check_all_zero("reset");
    @(posedge clock);
    #1 in_empty = 1'b1;
    reset = 1'b1;
    idle(2);

    // Luma on primaries and white, isolated pixels.
    send(24'hFF0000, 2'd2); idle(3);
    send(24'h00FF00, 2'd2); idle(3);
    send(24'hFFFFFF, 2'd2); idle(3);
    // Back-to-back with a mode change on every pixel.
    send({8'd31, 8'd20, 8'd10}, 2'd1);
    send({8'd10, 8'd200, 8'd31}, 2'd3);
    send(24'h123456, 2'd0);
    send({8'd255, 8'd255, 8'd254}, 2'd1);
    drain();

    // Frame counting from a fresh reset: 10 continuous pixels.
    do_reset();
    for (int i = 0; i < 10; i++) send(24'($urandom), 2'($urandom_range(0, 3)));
    drain();
    check("frame_count_end", 32'(pixel_count), 32'd2);
    check("frame_done_pulses", 32'(fd_cnt), 32'd2);

    // Random stream with gaps and random backpressure.
    chk_lat = 1'b0;
    bp_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(24'($urandom), 2'($urandom_range(0, 3)));
    end
    bp_en = 1'b0;
    out_full = 1'b0;
    drain();

    // Reset with two pixels in flight and pixel_count at 3.
    do_reset();
    chk_lat = 1'b1;
    for (int i = 0; i < 3; i++) send(24'($urandom), 2'd0);
    drain();
    check("pre_reset_count", 32'(pixel_count), 32'd3);
    chk_lat = 1'b0;
    out_full = 1'b1;
    send(24'h111111, 2'd0);
    send(24'h222222, 2'd0);
    in_dout = 24'h333333;
    in_empty = 1'b0;
    idle(1);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_in_rd_en", 32'(in_rd_en), 32'd0);
    #2 reset = 1'b0;
    out_full = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 in_empty = 1'b1;
    reset = 1'b1;
    chk_lat = 1'b1;
    px = 24'h0A0B0C;
    send(px, 2'd3);
    drain();
    check("post_reset_count", 32'(pixel_count), 32'd1);

    // Mode 2 random stream with backpressure, ending on a frame boundary.
    do_reset();
    chk_lat = 1'b0;
    bp_en = 1'b1;
    for (int i = 0; i < 40; i++) send(24'($urandom), 2'd2);
    bp_en = 1'b0;
    out_full = 1'b0;
    drain();
    check("final_frames", 32'(fd_cnt), 32'd10);
    check("final_count", 32'(pixel_count), 32'd0);
    check("final_busy", 32'(busy), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grayscale_stream.md
# grayscale_stream

Parametrised pixel-conversion stage between the input FIFO and the output FIFO of `dut_system`. It replaces the fixed 24-bit grayscale path. It pulls one 3-channel pixel per cycle from a first-word-fall-through FIFO and applies a per-pixel selectable conversion (passthrough, average, luma, max). Results go to the output FIFO through a 2-stage stallable pipeline that never drops or duplicates a pixel, and it counts pixels so end-of-frame is flagged in hardware.

## Interface

- `CHANNEL_WIDTH`, 8: bits per colour channel.
- `FRAME_PIXELS`, 388800: pixels per frame (720*540); must be ≥ 1.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `mode`  in  2  conversion select, sampled with each accepted pixel.
- `in_dout`  in  3*CHANNEL_WIDTH  input FIFO head word.
  - `[W-1:0]` = B, `[2W-1:W]` = G, `[3W-1:2W]` = R, with W = CHANNEL_WIDTH.
- `in_empty`  in  1  input FIFO empty.
- `in_rd_en`  out  1  consume head word this cycle.
- `out_din`  out  3*CHANNEL_WIDTH  output word, same channel order.
- `out_full`  in  1  output FIFO full.
- `out_wr_en`  out  1  write `out_din` this cycle.
- `frame_done`  out  1  one-cycle pulse on the write of the last pixel of a frame.
- `pixel_count`  out  $clog2(FRAME_PIXELS+1)  pixels written in the current frame.
- `busy`  out  1  high while either pipeline stage holds a valid pixel.

## Operation

- Pipeline: stage S1 (capture pixel and mode, compute intermediates), then stage S2 (result register), each with its own valid bit.
- Handshake, combinational from state and inputs:
  - `out_wr_en` = v2 & !out_full.
  - s2_ready = !v2 | !out_full.
  - s1_ready = !v1 | s2_ready.
  - `in_rd_en` = !in_empty & s1_ready.
- `in_dout` is valid whenever `in_empty` = 0 (FWFT); a word is consumed on the edge where `in_rd_en` = 1.
- Modes (Y replicated into all three channels of `out_din` for modes 1–3):
  - 0 passthrough: `out_din` = input word.
  - 1 average: Y = floor((R+G+B)/3), exact.
  - 2 luma: Y = (77R + 150G + 29B + 128) >> 8. The weights sum to 256, so Y ≤ 2^W−1 and no saturation is needed.
  - 3 max: Y = max(R,G,B).
- Width rules:
  - Sums are carried in W+2 bits; luma products in W+9 bits.
  - No truncation is allowed before the final shift/divide.
- Frame counter:
  - Increments on every `out_wr_en`.
  - On the write that takes it to FRAME_PIXELS, `frame_done` = 1 in that same cycle (combinational from the write), and `pixel_count` returns to 0 on that edge.
- Mode travels with its pixel. Changing `mode` mid-stream affects only pixels accepted after the change.

## Timing

- Reset (`reset` = 0, asynchronous) clears:
  - v1, v2 = 0.
  - `pixel_count` = 0.
  - `out_din` = 0.
  - `out_wr_en`, `in_rd_en`, `frame_done`, `busy` all low while reset is held.
- Reset mid-frame discards in-flight pixels. The frame count restarts at 0 after release.
- Latency:
  - Pixel consumed in cycle c appears with `out_wr_en` = 1 in cycle c+2 if `out_full` = 0.
  - Under continuous input and no backpressure, throughput is 1 pixel/cycle.
- Backpressure:
  - With `out_full` = 1, S2 holds and `out_din` is stable.
  - S1 may still fill if empty, then stalls.
  - At most 2 pixels are buffered; `in_rd_en` drops in the same cycle.
- Simultaneous write and accept: when S2 drains while S1 advances and a new pixel enters, all three happen on one edge with no bubble.
- `in_empty` gaps insert bubbles (v = 0); nothing is written for bubbles.
- `pixel_count` wraps: FRAME_PIXELS−1 plus one write gives 0. Back-to-back frames need no idle cycle.
- With FRAME_PIXELS = 1, `frame_done` pulses on every write.

## Test plan

- Mode 2, single pixel R,G,B = (255,0,0), then (0,255,0), then (255,255,255) → `out_din` channels = 77, 149, 255; each write appears exactly 2 cycles after its `in_rd_en`.
- Mode 1 on (31,20,10) → 20; mode 3 on (10,200,31) → 200; mode 0 on 0x123456 → 0x123456.
  - Switch mode every pixel; each output uses its own pixel's mode.
- Stream 16 pixels with `out_full` toggled randomly (about 50%) and `in_empty` gaps.
  - Output sequence equals the reference model exactly: no loss, no duplicates.
  - `out_din` is stable during every full cycle, and no write occurs while `out_full` = 1.
- FRAME_PIXELS = 4, stream 10 pixels continuously:
  - `frame_done` pulses on writes 4 and 8 only.
  - `pixel_count` reads 2 at the end.
- Assert `reset` low with 2 pixels in flight and `pixel_count` = 3:
  - All outputs go to 0 immediately (asynchronous).
  - After release, the next pixel is written with `pixel_count` 0→1 and none of the discarded pixels appear.
- Full frame of 720×540 at 8 bits, mode 2, randomised backpressure → exactly 388800 writes, one `frame_done`, `busy` = 0 at the end.
